// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter for the write port of an async FIFO.
// A winner keeps the port for up to BURST_MAX beats, then ownership rotates after one idle cycle.
module afifo_wr_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned OW       = $clog2(NUM_REQ)
) (
  input  logic                     clk_a,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         wr_data,
  output logic                     busy,
  output logic [OW-1:0]            owner
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      last_owner_q;
  logic [3:0]         beat_cnt_q;

  logic [OW-1:0]      winner;
  logic [OW-1:0]      idx;
  logic               found;
  logic               beat;
  logic [3:0]         beat_cnt_inc;
  logic [WIDTH-1:0]   slices [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slices[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Search starts just after the last owner; NUM_REQ is a power of two so the add wraps for free.
  always_comb begin
    winner = last_owner_q;
    idx    = last_owner_q;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = last_owner_q + OW'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign beat         = (state_q == StBurst) && req[owner_q] && !full;
  assign beat_cnt_inc = beat_cnt_q + 4'd1;

  assign busy    = (state_q == StBurst);
  assign wr_en   = beat && rst_n;
  assign wr_data = busy ? slices[owner_q] : '0;
  assign gnt     = gnt_q;
  assign owner   = owner_q;

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q    <= StBurst;
            owner_q    <= winner;
            gnt_q      <= NUM_REQ'(1) << winner;
            beat_cnt_q <= '0;
          end
        end
        StBurst: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_inc;
            if (beat_cnt_inc == 4'(BURST_MAX)) begin
              state_q      <= StIdle;
              last_owner_q <= owner_q;
              gnt_q        <= '0;
            end
          end else if (!req[owner_q]) begin
            state_q      <= StIdle;
            last_owner_q <= owner_q;
            gnt_q        <= '0;
          end
          // Otherwise full is stalling the owner: hold everything.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Bench for afifo_wr_arb: constant vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_afifo_wr_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned BM = 4;

  logic          clk_a;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*W-1:0] req_data;
  logic          full;
  logic [NR-1:0] gnt;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          busy;
  logic [1:0]    owner;

  afifo_wr_arb #(
    .NUM_REQ  (NR),
    .WIDTH    (W),
    .BURST_MAX(BM)
  ) dut (
    .clk_a   (clk_a),
    .rst_n   (rst_n),
    .req     (req),
    .req_data(req_data),
    .full    (full),
    .gnt     (gnt),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 when idle), last owner, beats in this burst.
  int m_cur   = -1;
  int m_last  = 3;
  int m_owner = 0;
  int m_beats = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur   = -1;
    m_owner = 0;
    m_last  = NR - 1;
    m_beats = 0;
  endtask

  // One clock cycle: drive inputs, check against the model, clock, advance the model.
  task automatic step(input logic r, input logic [3:0] rq, input logic f, input logic [31:0] d,
                      output logic [3:0] a_gnt, output logic a_wr, output logic a_busy,
                      output logic [1:0] a_own);
    logic [3:0]  e_gnt;
    logic        e_wr;
    logic [31:0] sh;
    logic [7:0]  e_wd;
    rst_n    = r;
    req      = rq;
    full     = f;
    req_data = d;
    #1;
    e_gnt = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
    e_wr  = (m_cur >= 0) && rq[m_cur] && !f && r;
    sh    = (m_cur >= 0) ? (d >> (8 * m_cur)) : 32'd0;
    e_wd  = sh[7:0];
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("wr_data", 32'(wr_data), 32'(e_wd));
    chk("busy", 32'(busy), 32'(m_cur >= 0));
    chk("owner", 32'(owner), 32'(m_owner));
    a_gnt  = gnt;
    a_wr   = wr_en;
    a_busy = busy;
    a_own  = owner;
    @(posedge clk_a);
    if (!r) begin
      model_reset();
    end else if (m_cur < 0) begin
      if (rq != 4'b0000) begin
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_last + k) % NR;
          if (rq[i]) begin
            m_cur   = i;
            m_owner = i;
            m_beats = 0;
            break;
          end
        end
      end
    end else if (e_wr) begin
      m_beats++;
      if (m_beats == BM) begin
        m_last = m_cur;
        m_cur  = -1;
      end
    end else if (!rq[m_cur]) begin
      m_last = m_cur;
      m_cur  = -1;
    end
    @(negedge clk_a);
  endtask

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       f;
    logic [3:0] g;
    logic       w;
    logic       b;
    logic [1:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic f,
                              input logic [3:0] g, input logic w, input logic b,
                              input logic [1:0] o);
    vec_t v;
    v.r = r; v.rq = rq; v.f = f; v.g = g; v.w = w; v.b = b; v.o = o;
    return v;
  endfunction

  logic [3:0] a_gnt;
  logic       a_wr;
  logic       a_busy;
  logic [1:0] a_own;

  initial begin
    int owners[$];
    int beats_q[$];
    int gaps_q[$];
    int beat_run;
    int idle_run;
    logic prev_busy;
    int occ;
    int writes;
    int viol;
    logic [3:0] rq;
    int exp_own[5];

    rst_n = 1'b0; req = '0; req_data = '0; full = 1'b0;
    repeat (2) @(posedge clk_a);
    @(negedge clk_a);
    model_reset();

    // Single requester: grant one cycle later, 4 beats, bubble, regrant; then mid-burst reset.
    tbl.push_back(mk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0));
    repeat (4) tbl.push_back(mk(1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 2'd0));
    tbl.push_back(mk(1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mk(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].f, $urandom, a_gnt, a_wr, a_busy, a_own);
      chk($sformatf("tbl%0d.gnt", i), 32'(a_gnt), 32'(tbl[i].g));
      chk($sformatf("tbl%0d.wr_en", i), 32'(a_wr), 32'(tbl[i].w));
      chk($sformatf("tbl%0d.busy", i), 32'(a_busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d.owner", i), 32'(a_own), 32'(tbl[i].o));
    end

    // All four requesting: owners rotate 0,1,2,3,0 with 4 beats each and a 1-cycle bubble.
    step(1'b0, 4'h0, 1'b0, 32'd0, a_gnt, a_wr, a_busy, a_own);
    prev_busy = 1'b0; beat_run = 0; idle_run = 0;
    for (int c = 0; c < 26; c++) begin
      step(1'b1, 4'hf, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
      if (a_busy && !prev_busy) begin
        owners.push_back(int'(a_own));
        if (owners.size() > 1) gaps_q.push_back(idle_run);
        beat_run = 0;
      end
      if (!a_busy && prev_busy) beats_q.push_back(beat_run);
      if (a_busy) begin
        idle_run = 0;
        if (a_wr) beat_run++;
      end else begin
        idle_run++;
      end
      prev_busy = a_busy;
    end
    exp_own = '{0, 1, 2, 3, 0};
    chk("rr.num_bursts", 32'(owners.size()), 32'd5);
    for (int i = 0; i < owners.size() && i < 5; i++)
      chk($sformatf("rr.owner%0d", i), 32'(owners[i]), 32'(exp_own[i]));
    foreach (beats_q[i]) chk($sformatf("rr.beats%0d", i), 32'(beats_q[i]), 32'd4);
    foreach (gaps_q[i]) chk($sformatf("rr.gap%0d", i), 32'(gaps_q[i]), 32'd1);

    // Requester 2, full for 3 cycles after beat 2.
    step(1'b0, 4'h0, 1'b0, 32'd0, a_gnt, a_wr, a_busy, a_own);
    step(1'b1, 4'h4, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    repeat (2) step(1'b1, 4'h4, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h4, 1'b1, $urandom, a_gnt, a_wr, a_busy, a_own);
      chk("stall.wr_en", 32'(a_wr), 32'd0);
      chk("stall.gnt", 32'(a_gnt), 32'h4);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'h4, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
      chk("stall.resume_wr", 32'(a_wr), 32'd1);
    end
    step(1'b1, 4'h4, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("stall.exit_busy", 32'(a_busy), 32'd0);

    // Requester 1 drops after 2 beats while requester 3 waits.
    step(1'b0, 4'h0, 1'b0, 32'd0, a_gnt, a_wr, a_busy, a_own);
    step(1'b1, 4'h2, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    repeat (2) step(1'b1, 4'ha, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    step(1'b1, 4'h8, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("drop.no_wr", 32'(a_wr), 32'd0);
    step(1'b1, 4'h8, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("drop.idle_gnt", 32'(a_gnt), 32'h0);
    step(1'b1, 4'h8, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("drop.regrant", 32'(a_gnt), 32'h8);

    // Reset during beat 2 of requester 3; next grant goes to requester 0.
    step(1'b0, 4'h0, 1'b0, 32'd0, a_gnt, a_wr, a_busy, a_own);
    step(1'b1, 4'h8, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    step(1'b1, 4'h8, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("rst.beat1", 32'(a_wr), 32'd1);
    step(1'b0, 4'h8, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("rst.no_wr", 32'(a_wr), 32'd0);
    step(1'b1, 4'h9, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("rst.idle", 32'(a_busy), 32'd0);
    step(1'b1, 4'h9, 1'b0, $urandom, a_gnt, a_wr, a_busy, a_own);
    chk("rst.gnt0", 32'(a_gnt), 32'h1);

    // Against a depth-4 FIFO with no reads: exactly 4 writes, none while full.
    step(1'b0, 4'h0, 1'b0, 32'd0, a_gnt, a_wr, a_busy, a_own);
    occ = 0; writes = 0; viol = 0;
    for (int c = 0; c < 20; c++) begin
      logic f;
      f = (occ >= 4);
      step(1'b1, 4'hf, f, $urandom, a_gnt, a_wr, a_busy, a_own);
      if (a_wr && f) viol++;
      if (a_wr) begin
        occ++;
        writes++;
      end
    end
    chk("fifo.writes", 32'(writes), 32'd4);
    chk("fifo.wr_while_full", 32'(viol), 32'd0);

    // Randomized traffic against the model.
    step(1'b0, 4'h0, 1'b0, 32'd0, a_gnt, a_wr, a_busy, a_own);
    rq = 4'h0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(($urandom_range(0, 59) != 0), rq, ($urandom_range(0, 3) == 0), $urandom,
           a_gnt, a_wr, a_busy, a_own);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arb.md
AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing the afifo write port; a power of two, at least 2.
REQ-002 Parameter WIDTH, default 1: data width, equal to the afifo WIDTH.
REQ-003 Parameter BURST_MAX, default 4: maximum beats per grant before ownership rotates; range 1..15.
REQ-004 Port clk_a, input, 1 bit: the single clock for the block, the afifo write-side clock.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk_a.
REQ-006 Port req, input, NUM_REQ bits: bit i high means requester i has a beat ready.
REQ-007 Port req_data, input, NUM_REQ*WIDTH bits: slice [i*WIDTH +: WIDTH] is requester i's data.
REQ-008 Port full, input, 1 bit: afifo full flag, in the clk_a domain.
REQ-009 Port gnt, output, NUM_REQ bits: registered one-hot grant, all zeros when no owner.
REQ-010 Port wr_en, output, 1 bit: afifo write enable.
REQ-011 Port wr_data, output, WIDTH bits: afifo write data.
REQ-012 Port busy, output, 1 bit: high while in state BURST.
REQ-013 Port owner, output, log2(NUM_REQ) bits: index of the current or last owner.

Function
REQ-014 The FSM SHALL have two states, IDLE and BURST; busy = (state == BURST).
REQ-015 In IDLE with req != 0, the block SHALL pick the winner round-robin, starting from the requester after last_owner and wrapping from NUM_REQ-1 to 0.
REQ-016 On that edge the block SHALL set state = BURST, owner = winner, gnt = one-hot(winner), and beat_cnt = 0.
REQ-017 In IDLE with req == 0, the block SHALL hold all state and keep gnt = 0.
REQ-018 wr_en SHALL be combinational: (state == BURST) && req[owner] && !full && rst_n.
REQ-019 A beat is a cycle with wr_en = 1; the afifo is never written while full is high.
REQ-020 wr_data SHALL be req_data[owner] combinationally whenever busy is high, and 0 in IDLE.
REQ-021 Each beat SHALL increment beat_cnt (4 bits).
REQ-022 When full = 1 and req[owner] = 1, the block SHALL stall: stay in BURST, keep gnt, keep beat_cnt.
REQ-023 The block SHALL exit BURST to IDLE on the edge after the beat that makes beat_cnt == BURST_MAX.
REQ-024 The block SHALL also exit BURST to IDLE on any edge where req[owner] = 0, and no beat occurs in that cycle.
REQ-025 On exit, last_owner SHALL be set to owner and gnt SHALL be cleared.
REQ-026 IDLE lasts at least one cycle between bursts, so each burst is followed by a one-cycle arbitration bubble.
REQ-027 Requests from non-owners during BURST SHALL be ignored and do not preempt the owner.
REQ-028 A requester that keeps req high is granted again only after every other active requester has had a turn.
REQ-029 full rising in the same cycle as the last allowed beat SHALL block that beat; the burst stalls and beat_cnt is not incremented.
REQ-030 Changes on req_data outside the owner's slice SHALL have no effect on any output.

Reset
REQ-031 While rst_n is low at a clk_a edge, the block SHALL set state = IDLE, gnt = 0, owner = 0, last_owner = NUM_REQ-1, and beat_cnt = 0.
REQ-032 While rst_n is low, wr_en SHALL be 0 combinationally.
REQ-033 After release, requester 0 has first priority.
REQ-034 A reset asserted mid-burst SHALL abort the burst without any further write; the first grant after release goes to the lowest-index active requester.
REQ-035 Outputs after reset: gnt = 0, wr_en = 0, wr_data = 0, busy = 0, owner = 0.

Verification
REQ-036 Scenario: reset, then req = 4'b0001 held, full = 0. Response: gnt = 0001 one cycle later, then exactly 4 wr_en pulses, one IDLE cycle, then regrant to requester 0.
REQ-037 Scenario: req = 4'b1111 held, full = 0. Response: owner sequence 0, 1, 2, 3, 0; 4 beats each; busy low for exactly 1 cycle between bursts.
REQ-038 Scenario: requester 2 owns the grant, and full is driven high for 3 cycles after beat 2. Response: wr_en = 0 for those 3 cycles, gnt holds 0100, beats 3 and 4 follow, then exit.
REQ-039 Scenario: requester 1 owns the grant and drops req after 2 beats while req[3] = 1. Response: IDLE for 1 cycle, then gnt = 1000.
REQ-040 Scenario: rst_n pulled low for 1 cycle during beat 2 of requester 3. Response: wr_en = 0 in that cycle; state IDLE next; with req = 4'b1001, the next grant goes to requester 0.
REQ-041 Scenario: connected to afifo with DEPTH = 4 and the read side idle. Response: exactly 4 writes accepted, and no wr_en while full = 1.
